// File: rtl/div_pkg.sv
// Shared opcode and FSM encodings for the divide issue controller and divider wrapper.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_special_case.sv
// Detects divide-by-zero and signed overflow and picks the architecturally defined result.
module div_special_case
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [1:0]      op,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic div_by_zero;
  logic overflow;
  logic is_quotient;
  logic is_signed;

  always_comb begin
    is_quotient    = (op == DIV) || (op == DIVU);
    is_signed      = (op == DIV) || (op == REM);
    div_by_zero    = (rs2 == '0);
    overflow       = is_signed && (rs1 == MIN_NEG) && (rs2 == '1);
    is_special     = div_by_zero || overflow;
    special_result = '0;
    // Divide-by-zero wins when both apply (impossible in practice: rs2 cannot be 0 and all-ones).
    if (div_by_zero)
      special_result = is_quotient ? '1 : rs1;
    else if (overflow)
      special_result = is_quotient ? rs1 : '0;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller for a multi-cycle divider; short-circuits special cases and drains on flush.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic [1:0]      div_operation,
  output logic            div_data_valid,
  input  logic [XLEN-1:0] div_result,
  input  logic            div_ready,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ack,
  output logic            busy
);

  div_state_e      state;
  logic            accept;
  logic            is_special;
  logic [XLEN-1:0] special_result;

  div_special_case #(.XLEN(XLEN)) u_special (
    .rs1            (req_rs1),
    .rs2            (req_rs2),
    .op             (req_op),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      div_dividend   <= '0;
      div_divisor    <= '0;
      div_operation  <= '0;
      div_data_valid <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_dividend  <= req_rs1;
            div_divisor   <= req_rs2;
            div_operation <= req_op;
            wb_rd         <= req_rd;
            if (is_special) begin
              wb_data  <= special_result;
              wb_valid <= 1'b1;
              state    <= DONE;
            end else begin
              div_data_valid <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_data_valid <= 1'b0;
          if (flush) state <= DRAIN;
          else       state <= WAIT;
        end
        WAIT: begin
          // A result arriving with the flush means the divider is already idle: skip DRAIN.
          if (flush) begin
            if (div_ready) state <= IDLE;
            else           state <= DRAIN;
          end else if (div_ready) begin
            wb_data  <= div_result;
            wb_valid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (flush || wb_ack) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (div_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
